md_sched: RTL and testbench

- Sequencer and issue controller for the multiply/divide resource in the E stage.
- Accepts mult/multu/div/divu/mthi/mtlo operations from E and holds the operands.
- Models the unit's latency with a countdown FSM and commits results to the architectural HI/LO registers.
- Drives the busy/stall signal for the hazard unit, and supports exception flush (abort in-flight op) and HI/LO rollback of the last mthi/mtlo.

---
 rtl/md_sched.sv | 112 +++++++++++
 tb/tb_md_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// md_sched: multiply/divide issue sequencer with latency countdown, HI/LO commit, flush and mthi/mtlo rollback.
module md_sched #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mf_req,
    input  logic        flush,
    input  logic        restore,
    output logic        accept,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW = $clog2(MAX_LAT + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   stage_hi, stage_lo, shadow_hi, shadow_lo;
    logic          is_op, is_mul, is_div, is_md, commit;
    logic [63:0]   prod_s, prod_u, res;
    logic [31:0]   quo_s, rem_s, quo_u, rem_u, div_hi, div_lo;
    logic          b_zero, ovf;

    assign is_op  = op_valid && op != 3'd0 && op != 3'd7;
    assign is_mul = op == 3'd1 || op == 3'd2;
    assign is_div = op == 3'd3 || op == 3'd4;
    assign is_md  = is_mul || is_div;
    assign accept = is_op && state == IDLE && !flush && !restore;
    assign busy   = (accept && is_md) || state == RUN;
    assign stall  = (is_op || mf_req) && state == RUN;

    assign prod_s = 64'($signed(src_a)) * 64'($signed(src_b));
    assign prod_u = 64'(src_a) * 64'(src_b);
    assign quo_s  = 32'($signed(src_a) / $signed(src_b));
    assign rem_s  = 32'($signed(src_a) % $signed(src_b));
    assign quo_u  = src_a / src_b;
    assign rem_u  = src_a % src_b;
    assign b_zero = src_b == 32'd0;
    // signed overflow case would trap in software; pin it to the MIPS-visible result
    assign ovf    = op == 3'd3 && src_a == 32'h8000_0000 && src_b == 32'hFFFF_FFFF;
    assign div_lo = b_zero ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : (op == 3'd3 ? quo_s : quo_u);
    assign div_hi = b_zero ? src_a : ovf ? 32'd0 : (op == 3'd3 ? rem_s : rem_u);
    assign res    = op == 3'd1 ? prod_s : op == 3'd2 ? prod_u : {div_hi, div_lo};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        commit  = 1'b0;
        if (state == RUN) begin
            if (flush) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else if (cnt == '0) begin
                state_n = IDLE;
                commit  = 1'b1;
            end else begin
                cnt_n = cnt - 1'b1;
            end
        end else if (accept && is_md) begin
            state_n = RUN;
            cnt_n   = is_mul ? CW'(MUL_LAT - 1) : CW'(DIV_LAT - 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi        <= '0;
            lo        <= '0;
            stage_hi  <= '0;
            stage_lo  <= '0;
            shadow_hi <= '0;
            shadow_lo <= '0;
        end else begin
            if (accept && is_md)
                {stage_hi, stage_lo} <= res;
            if (commit) begin
                hi <= stage_hi;
                lo <= stage_lo;
            end else if (restore && state == IDLE) begin
                hi <= shadow_hi;
                lo <= shadow_lo;
            end else if (accept && !is_md) begin
                shadow_hi <= hi;
                shadow_lo <= lo;
                if (op == 3'd5)
                    hi <= src_a;
                else
                    lo <= src_a;
            end
        end
    end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed-vector bench for md_sched with hand-computed HI/LO and timing expectations.
module tb_md_sched;
    logic        clk = 1'b0, reset = 1'b1;
    logic        op_valid = 1'b0, mf_req = 1'b0, flush = 1'b0, restore = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        accept, busy, stall;
    logic [31:0] hi, lo;
    int          tests = 0, fails = 0, nb;

    md_sched #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .mf_req(mf_req), .flush(flush),
        .restore(restore), .accept(accept), .busy(busy), .stall(stall),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
    endtask

    // issue and count busy cycles; returns at the negedge of the first non-busy cycle
    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int n);
        drive(o, a, b);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            @(posedge clk); #1;
            op_valid = 1'b0;
        end
        op_valid = 1'b0;
    endtask

    // issue and leave the bench just after the T+1 edge
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        drive(o, a, b);
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic write_hl(input logic [2:0] o, input logic [31:0] a);
        drive(o, a, 32'd0);
        @(negedge clk);
        check("mt_accept", {31'd0, accept}, 32'd1);
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #12 reset = 1'b0;
        @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_ctl", {29'd0, accept, busy, stall}, 32'd0);

        run(3'd1, 32'hFFFF_FFFF, 32'd2, nb);
        check("mult_busy", 32'(nb), 32'd6);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);

        run(3'd2, 32'hFFFF_FFFF, 32'd2, nb);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        run(3'd3, 32'hFFFF_FFF9, 32'd2, nb);
        check("div_busy", 32'(nb), 32'd11);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        run(3'd4, 32'd5, 32'd0, nb);
        check("divz_lo", lo, 32'hFFFF_FFFF);
        check("divz_hi", hi, 32'd5);

        run(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        // flush at T+4
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        check("fl4_busy_in", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("fl4_busy_out", {31'd0, busy}, 32'd0);
        repeat (12) @(negedge clk);
        check("fl4_hi", hi, 32'd0);
        check("fl4_lo", lo, 32'h8000_0000);

        // flush in the commit cycle T+10
        issue(3'd3, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("fl10_busy", {31'd0, busy}, 32'd0);
        check("fl10_hi", hi, 32'd0);
        check("fl10_lo", lo, 32'h8000_0000);

        // flush in IDLE blocks issue
        drive(3'd1, 32'd3, 32'd3);
        flush = 1'b1;
        @(negedge clk);
        check("fl_idle_acc", {30'd0, accept, busy}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        check("fl_idle_busy", {31'd0, busy}, 32'd0);

        // mthi held off while RUN, then accepted right after commit
        issue(3'd1, 32'd3, 32'd4);
        op_valid = 1'b1; op = 3'd5; src_a = 32'h1234;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall) break;
            nb++;
            if (accept) check("run_accept", {31'd0, accept}, 32'd0);
        end
        check("mt_stall_cyc", 32'(nb), 32'd5);
        check("mt_acc_after", {31'd0, accept}, 32'd1);
        check("mt_lo_commit", lo, 32'd12);
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        check("mt_hi", hi, 32'h1234);

        // mf_req stalls only while RUN
        issue(3'd1, 32'd2, 32'd3);
        mf_req = 1'b1;
        @(negedge clk);
        check("mf_stall", {31'd0, stall}, 32'd1);
        mf_req = 1'b0;
        wait_idle();
        mf_req = 1'b1;
        @(negedge clk);
        check("mf_idle", {31'd0, stall}, 32'd0);
        mf_req = 1'b0;
        check("mf_lo", lo, 32'd6);

        // op 7 is a no-op
        drive(3'd7, 32'd1, 32'd1);
        @(negedge clk);
        check("op7", {30'd0, accept, busy}, 32'd0);
        op_valid = 1'b0;

        // restore after mthi
        write_hl(3'd5, 32'hAAAA);
        write_hl(3'd5, 32'h5555);
        @(negedge clk);
        check("mthi2", hi, 32'h5555);
        restore = 1'b1;
        @(posedge clk); #1;
        restore = 1'b0;
        @(negedge clk);
        check("rest_hi", hi, 32'hAAAA);
        check("rest_lo", lo, 32'd6);

        // async reset mid-div
        issue(3'd4, 32'd50, 32'd3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("amid_hi", hi, 32'd0);
        check("amid_lo", lo, 32'd0);
        check("amid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("post_rst_lo", lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
